// File: rtl/mc_loader.sv
// rtl/mc_loader.sv - boot-time loader that assembles a byte stream into microcode words and writes the control store
// Ports:
//   clk, _reset            : clock, asynchronous active-low reset
//   start, load_base,      : load request; base address and word count captured
//   load_len               :   when a start is accepted in IDLE or DONE
//   byte_in, byte_valid,   : incoming byte stream, consumed when byte_valid & byte_ready
//   byte_ready             :
//   mc_addr, mc_data       : control-store address and write data
//   _mc_cs, _mc_w, _mc_oe  : control-store chip select, write strobe, output enable (all active-low)
//   busy, done             : load in progress / last requested load finished
module mc_loader #(
    parameter int WIDTH     = 64,
    parameter int ADDR_BITS = 8,
    parameter int WE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 _reset,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] load_base,
    input  logic [ADDR_BITS:0]   load_len,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic [ADDR_BITS-1:0] mc_addr,
    output logic [WIDTH-1:0]     mc_data,
    output logic                 _mc_cs,
    output logic                 _mc_w,
    output logic                 _mc_oe,
    output logic                 busy,
    output logic                 done
);
    localparam int BYTES = WIDTH / 8;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WCW   = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    localparam logic [ADDR_BITS:0] LEN_MAX   = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0] LEN_ONE   = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [CW-1:0]      BCNT_LAST = CW'(BYTES - 1);
    localparam logic [WCW-1:0]     WCNT_LAST = WCW'(WE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SETUP,
        S_WRITE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t               state_q,      state_d;
    logic [ADDR_BITS-1:0] mc_addr_q,    mc_addr_d;
    logic [WIDTH-1:0]     mc_data_q,    mc_data_d;
    logic [ADDR_BITS:0]   remaining_q,  remaining_d;
    logic [CW-1:0]        byte_cnt_q,   byte_cnt_d;
    logic [WCW-1:0]       we_cnt_q,     we_cnt_d;
    logic                 byte_ready_q, byte_ready_d;
    logic                 mc_cs_n_q,    mc_cs_n_d;
    logic                 mc_w_n_q,     mc_w_n_d;
    logic                 busy_q,       busy_d;
    logic                 done_q,       done_d;

    always_comb begin
        state_d     = state_q;
        mc_addr_d   = mc_addr_q;
        mc_data_d   = mc_data_q;
        remaining_d = remaining_q;
        byte_cnt_d  = byte_cnt_q;
        we_cnt_d    = we_cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mc_addr_d   = load_base;
                    remaining_d = (load_len > LEN_MAX) ? LEN_MAX : load_len;
                    byte_cnt_d  = '0;
                    state_d     = (load_len == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                // byte_ready_q is high for every cycle spent in FILL
                if (byte_valid && byte_ready_q) begin
                    for (int k = 0; k < BYTES; k++) begin
                        if (byte_cnt_q == CW'(k)) begin
                            mc_data_d[8*k +: 8] = byte_in;
                        end
                    end
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == BCNT_LAST) begin
                        we_cnt_d = '0;
                        state_d  = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (we_cnt_q == WCNT_LAST) begin
                    state_d = S_HOLD;
                end else begin
                    we_cnt_d = we_cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                mc_addr_d   = mc_addr_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                byte_cnt_d  = '0;
                state_d     = (remaining_q == LEN_ONE) ? S_DONE : S_FILL;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so each pin is a clean flop.
        byte_ready_d = (state_d == S_FILL);
        mc_cs_n_d    = !(state_d inside {S_SETUP, S_WRITE, S_HOLD});
        mc_w_n_d     = (state_d != S_WRITE);
        busy_d       = state_d inside {S_FILL, S_SETUP, S_WRITE, S_HOLD};
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q      <= S_IDLE;
            mc_addr_q    <= '0;
            mc_data_q    <= '0;
            remaining_q  <= '0;
            byte_cnt_q   <= '0;
            we_cnt_q     <= '0;
            byte_ready_q <= 1'b0;
            mc_cs_n_q    <= 1'b1;
            mc_w_n_q     <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mc_addr_q    <= mc_addr_d;
            mc_data_q    <= mc_data_d;
            remaining_q  <= remaining_d;
            byte_cnt_q   <= byte_cnt_d;
            we_cnt_q     <= we_cnt_d;
            byte_ready_q <= byte_ready_d;
            mc_cs_n_q    <= mc_cs_n_d;
            mc_w_n_q     <= mc_w_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign mc_addr    = mc_addr_q;
    assign mc_data    = mc_data_q;
    assign _mc_cs     = mc_cs_n_q;
    assign _mc_w      = mc_w_n_q;
    assign _mc_oe     = 1'b1;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule
